// File: rtl/dtbdm_pkg.sv
`default_nettype none
// ============================================================================
// dtbdm_pkg : shared state encoding, window indices and frame defaults
// Rev 1.0
// ============================================================================
package dtbdm_pkg;

  typedef enum logic [1:0] {
    sIdle  = 2'd0,
    sRun   = 2'd1,
    sFlush = 2'd2,
    sDone  = 2'd3
  } tSeqState;

  // Window positions, row-major: a b c / d fij e / f g h
  localparam int c_idxA   = 0;
  localparam int c_idxB   = 1;
  localparam int c_idxC   = 2;
  localparam int c_idxD   = 3;
  localparam int c_idxFij = 4;
  localparam int c_idxE   = 5;
  localparam int c_idxF   = 6;
  localparam int c_idxG   = 7;
  localparam int c_idxH   = 8;
  localparam int c_winSize = 9;

  localparam int c_defWidth  = 640;
  localparam int c_defHeight = 480;

endpackage
`default_nettype wire

// File: rtl/mLineBuffer.sv
`default_nettype none
// ============================================================================
// mLineBuffer : one image row of pixels, combinational read-before-write
// Rev 1.0
// ============================================================================
module mLineBuffer #(
  parameter int pWidth    = 640,
  parameter int pAddrBits = 10
) (
  input  logic                 iClk,
  input  logic                 iWe,
  input  logic [pAddrBits-1:0] ivAddr,
  input  logic [7:0]           iv8Data,
  output logic [7:0]           ov8Data
);

  logic [7:0] r_mem [pWidth];

  // Read sees the old content of the slot being overwritten this cycle
  assign ov8Data = r_mem[ivAddr];

  always_ff @(posedge iClk) begin
    if (iWe) begin
      r_mem[ivAddr] <= iv8Data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtbdm_window_sequencer.sv
`default_nettype none
// ============================================================================
// dtbdm_window_sequencer : raster pixels in, bordered 3x3 windows out
// Rev 1.0
// ============================================================================
module dtbdm_window_sequencer
  import dtbdm_pkg::*;
#(
  parameter int pWidth   = c_defWidth,
  parameter int pHeight  = c_defHeight,
  parameter int pColBits = 10
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iPixelValid,
  input  logic [7:0]          iv8PixelIn,
  output logic                oPixelReady,
  output logic [7:0]          ov8Pixel_a,
  output logic [7:0]          ov8Pixel_b,
  output logic [7:0]          ov8Pixel_c,
  output logic [7:0]          ov8Pixel_d,
  output logic [7:0]          ov8Pixel_e,
  output logic [7:0]          ov8Pixel_f,
  output logic [7:0]          ov8Pixel_g,
  output logic [7:0]          ov8Pixel_h,
  output logic [7:0]          ov8Pixel_fij,
  output logic                oDataValid,
  output logic                oEn,
  output logic                oBorder,
  output logic [pColBits-1:0] ovCol,
  output logic [pColBits-1:0] ovRow,
  output logic                oBusy,
  output logic                oFrameDone
);

  localparam int                c_lbAddrBits = $clog2(pWidth);
  localparam logic [pColBits-1:0] c_lastCol  = pColBits'(pWidth - 1);
  localparam logic [pColBits-1:0] c_lastRow  = pColBits'(pHeight - 1);

  tSeqState r_state, w_nextState;

  logic [pColBits-1:0] r_colIn, r_rowIn, r_emitCol, r_emitRow;
  logic                r_emitOn;
  logic [7:0]          r_colOld [3];
  logic [7:0]          r_colNew [3];
  logic [7:0]          w_colIn  [3];
  logic [7:0]          w_lb1Rd, w_lb2Rd;
  logic [7:0]          w_win [c_winSize];
  logic [7:0]          r_win [c_winSize];
  logic                w_accept, w_step, w_emit, w_lastIn, w_lastEmit;
  logic                w_left, w_right, w_top, w_bot;
  logic                r_dataValid, r_en, r_border, r_frameDone;
  logic [pColBits-1:0] r_col, r_row;

  assign w_accept   = (r_state == sRun) && iPixelValid;
  // FLUSH advances the same pipeline with a virtual pixel that is always masked
  assign w_step     = w_accept || (r_state == sFlush);
  assign w_emit     = w_step && r_emitOn;
  assign w_lastIn   = (r_colIn == c_lastCol) && (r_rowIn == c_lastRow);
  assign w_lastEmit = (r_emitCol == c_lastCol) && (r_emitRow == c_lastRow);

  // Row r-1 store feeds row r-2 store, forming the vertical column vector
  mLineBuffer #(.pWidth(pWidth), .pAddrBits(c_lbAddrBits)) uLineBuf1 (
    .iClk    (iClk),
    .iWe     (w_step),
    .ivAddr  (r_colIn[c_lbAddrBits-1:0]),
    .iv8Data (iv8PixelIn),
    .ov8Data (w_lb1Rd)
  );

  mLineBuffer #(.pWidth(pWidth), .pAddrBits(c_lbAddrBits)) uLineBuf2 (
    .iClk    (iClk),
    .iWe     (w_step),
    .ivAddr  (r_colIn[c_lbAddrBits-1:0]),
    .iv8Data (w_lb1Rd),
    .ov8Data (w_lb2Rd)
  );

  assign w_colIn[0] = w_lb2Rd;
  assign w_colIn[1] = w_lb1Rd;
  assign w_colIn[2] = iv8PixelIn;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= sIdle;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    oPixelReady = 1'b0;
    oBusy       = 1'b1;
    case (r_state)
      sIdle: begin
        oBusy = 1'b0;
        if (iStart) w_nextState = sRun;
      end
      sRun: begin
        oPixelReady = 1'b1;
        if (w_accept && w_lastIn) w_nextState = sFlush;
      end
      sFlush: begin
        if (w_emit && w_lastEmit) w_nextState = sDone;
      end
      sDone: begin
        w_nextState = sIdle;
      end
      default: begin
        w_nextState = sIdle;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_colIn   <= '0;
      r_rowIn   <= '0;
      r_emitCol <= '0;
      r_emitRow <= '0;
      r_emitOn  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_colOld[i] <= '0;
        r_colNew[i] <= '0;
      end
    end else if (r_state == sIdle) begin
      r_colIn   <= '0;
      r_rowIn   <= '0;
      r_emitCol <= '0;
      r_emitRow <= '0;
      r_emitOn  <= 1'b0;
    end else if (w_step) begin
      for (int i = 0; i < 3; i++) begin
        r_colOld[i] <= r_colNew[i];
        r_colNew[i] <= w_colIn[i];
      end
      if (r_colIn == c_lastCol) begin
        r_colIn <= '0;
        if (r_state == sRun) r_rowIn <= r_rowIn + pColBits'(1);
      end else begin
        r_colIn <= r_colIn + pColBits'(1);
      end
      // Step at index pWidth primes the pipe; the next step emits centre 0
      if ((r_rowIn == pColBits'(1)) && (r_colIn == '0)) r_emitOn <= 1'b1;
      if (w_emit) begin
        if (r_emitCol == c_lastCol) begin
          r_emitCol <= '0;
          r_emitRow <= r_emitRow + pColBits'(1);
        end else begin
          r_emitCol <= r_emitCol + pColBits'(1);
        end
      end
    end
  end

  assign w_left  = (r_emitCol == '0);
  assign w_right = (r_emitCol == c_lastCol);
  assign w_top   = (r_emitRow == '0);
  assign w_bot   = (r_emitRow == c_lastRow);

  // Left column = older shift stage, centre = newer stage, right = incoming
  always_comb begin
    w_win[c_idxFij] = r_colNew[1];
    w_win[c_idxA]   = (w_top || w_left)  ? r_colNew[1] : r_colOld[0];
    w_win[c_idxB]   = w_top              ? r_colNew[1] : r_colNew[0];
    w_win[c_idxC]   = (w_top || w_right) ? r_colNew[1] : w_colIn[0];
    w_win[c_idxD]   = w_left             ? r_colNew[1] : r_colOld[1];
    w_win[c_idxE]   = w_right            ? r_colNew[1] : w_colIn[1];
    w_win[c_idxF]   = (w_bot || w_left)  ? r_colNew[1] : r_colOld[2];
    w_win[c_idxG]   = w_bot              ? r_colNew[1] : r_colNew[2];
    w_win[c_idxH]   = (w_bot || w_right) ? r_colNew[1] : w_colIn[2];
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < c_winSize; i++) r_win[i] <= '0;
      r_dataValid <= 1'b0;
      r_en        <= 1'b0;
      r_border    <= 1'b0;
      r_frameDone <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
    end else begin
      r_dataValid <= w_emit;
      r_en        <= r_dataValid;
      r_frameDone <= (r_state == sDone);
      if (w_emit) begin
        for (int i = 0; i < c_winSize; i++) r_win[i] <= w_win[i];
        r_border <= w_left || w_right || w_top || w_bot;
        r_col    <= r_emitCol;
        r_row    <= r_emitRow;
      end
    end
  end

  assign ov8Pixel_a   = r_win[c_idxA];
  assign ov8Pixel_b   = r_win[c_idxB];
  assign ov8Pixel_c   = r_win[c_idxC];
  assign ov8Pixel_d   = r_win[c_idxD];
  assign ov8Pixel_fij = r_win[c_idxFij];
  assign ov8Pixel_e   = r_win[c_idxE];
  assign ov8Pixel_f   = r_win[c_idxF];
  assign ov8Pixel_g   = r_win[c_idxG];
  assign ov8Pixel_h   = r_win[c_idxH];
  assign oDataValid   = r_dataValid;
  assign oEn          = r_en;
  assign oBorder      = r_border;
  assign ovCol        = r_col;
  assign ovRow        = r_row;
  assign oFrameDone   = r_frameDone;

endmodule
`default_nettype wire

// File: tb/tb_dtbdm_window_sequencer.sv
`default_nettype none
// ============================================================================
// tb_dtbdm_window_sequencer : randomized frames against a window reference model
// Rev 1.0
// ============================================================================
module tb_dtbdm_window_sequencer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int L = W + 1;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iStart = 1'b0;
  logic       iPixelValid = 1'b0;
  logic [7:0] iv8PixelIn = '0;
  logic       oPixelReady, oDataValid, oEn, oBorder, oBusy, oFrameDone;
  logic [7:0] ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_e;
  logic [7:0] ov8Pixel_f, ov8Pixel_g, ov8Pixel_h, ov8Pixel_fij;
  logic [9:0] ovCol, ovRow;
  logic [71:0] w_dutWin;

  dtbdm_window_sequencer #(.pWidth(W), .pHeight(H), .pColBits(10)) uDut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iPixelValid(iPixelValid),
    .iv8PixelIn(iv8PixelIn), .oPixelReady(oPixelReady),
    .ov8Pixel_a(ov8Pixel_a), .ov8Pixel_b(ov8Pixel_b), .ov8Pixel_c(ov8Pixel_c),
    .ov8Pixel_d(ov8Pixel_d), .ov8Pixel_e(ov8Pixel_e), .ov8Pixel_f(ov8Pixel_f),
    .ov8Pixel_g(ov8Pixel_g), .ov8Pixel_h(ov8Pixel_h), .ov8Pixel_fij(ov8Pixel_fij),
    .oDataValid(oDataValid), .oEn(oEn), .oBorder(oBorder),
    .ovCol(ovCol), .ovRow(ovRow), .oBusy(oBusy), .oFrameDone(oFrameDone)
  );

  always #5 iClk = ~iClk;

  assign w_dutWin = {ov8Pixel_h, ov8Pixel_g, ov8Pixel_f, ov8Pixel_e, ov8Pixel_fij,
                     ov8Pixel_d, ov8Pixel_c, ov8Pixel_b, ov8Pixel_a};

  typedef struct packed {
    logic [71:0] p;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        border;
  } tWin;

  tWin        expQ [$];
  logic [7:0] img [N];
  int nChecks = 0;
  int nFail = 0;
  bit monOn = 1'b0;
  int acceptCount, schedCnt, expCnt, doneSeen, winSeen;
  bit curExp, prevExp, curDoneExp;
  logic [71:0] cap11;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_pixLo"}, w_dutWin[63:0], 64'd0);
    check({tag, "_pixHi"}, w_dutWin[71:64], 8'd0);
    check({tag, "_ctl"}, {oDataValid, oEn, oBorder, oBusy, oFrameDone, oPixelReady}, 6'd0);
    check({tag, "_coord"}, {ovCol, ovRow}, 20'd0);
  endtask

  // Every window straight from the image: off-image neighbours take the centre value
  task automatic buildExpected();
    tWin w;
    int rr, cc;
    logic [7:0] ctr, v;
    expQ.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        ctr      = img[r*W + c];
        w.p      = '0;
        w.col    = 10'(c);
        w.row    = 10'(r);
        w.border = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
              v = img[rr*W + cc];
            end else begin
              v = ctr;
              w.border = 1'b1;
            end
            w.p[((dr+1)*3 + (dc+1))*8 +: 8] = v;
          end
        end
        expQ.push_back(w);
      end
    end
  endtask

  always @(negedge iClk) begin
    tWin w;
    bit nextExp, nextDone;
    if (monOn) begin
      check("dataValid", oDataValid, curExp);
      check("enDelay", oEn, prevExp);
      check("frameDone", oFrameDone, curDoneExp);
      if (oFrameDone) doneSeen++;
      if (oDataValid) winSeen++;
      if (oDataValid && ovCol == 10'd1 && ovRow == 10'd1) cap11 = w_dutWin;
      if (curExp) begin
        check("winAvail", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          w = expQ.pop_front();
          check("winLo", w_dutWin[63:0], w.p[63:0]);
          check("winHi", w_dutWin[71:64], w.p[71:64]);
          check("coord", {ovCol, ovRow}, {w.col, w.row});
          check("border", oBorder, w.border);
          expCnt++;
        end
      end
      nextDone = curExp && (expCnt == N);
      if (iPixelValid && oPixelReady) begin
        nextExp = (acceptCount >= L);
        acceptCount++;
      end else begin
        nextExp = (acceptCount == N) && (schedCnt < N);
      end
      if (nextExp) schedCnt++;
      prevExp    = curExp;
      curExp     = nextExp;
      curDoneExp = nextDone;
    end
  end

  // mode 0: pixel=10k gap-free, 1: valid toggles, 2: random pixels/gaps
  task automatic runFrame(input int mode, input bit junkStart, input int abortAt);
    int sent, cyc, guard;
    bit v, rdy;
    monOn = 1'b0;
    for (int i = 0; i < N; i++) img[i] = (mode == 2) ? 8'($urandom) : 8'(10 * i);
    buildExpected();
    acceptCount = 0; schedCnt = 0; expCnt = 0; doneSeen = 0; winSeen = 0;
    curExp = 1'b0; prevExp = 1'b0; curDoneExp = 1'b0; cap11 = '0;
    @(posedge iClk); #1;
    monOn  = 1'b1;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    check("busyRun", oBusy, 1);
    sent = 0;
    cyc  = 0;
    while (sent < N && cyc < 400) begin
      if (abortAt >= 0 && sent == abortAt) break;
      rdy = oPixelReady;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      iPixelValid = v;
      iv8PixelIn  = v ? img[sent] : 8'($urandom);
      iStart      = junkStart && (cyc == 3);
      @(posedge iClk); #1;
      if (v && rdy) sent++;
      cyc++;
    end
    iPixelValid = 1'b0;
    iStart      = 1'b0;
    if (abortAt >= 0) begin
      monOn = 1'b0;
      #2 iRst = 1'b1;
      #1 checkZero("asyncRst");
      #3 iRst = 1'b0;
      return;
    end
    if (junkStart) begin
      iStart = 1'b1;
      @(posedge iClk); #1;
      iStart = 1'b0;
    end
    guard = 0;
    while (doneSeen == 0 && guard < 100) begin
      @(posedge iClk); #1;
      guard++;
    end
    check("doneReached", doneSeen != 0, 1);
    repeat (3) begin
      @(posedge iClk); #1;
    end
    check("doneCount", doneSeen, 1);
    check("winCount", winSeen, N);
    check("winDrained", expCnt, N);
    check("busyIdle", oBusy, 0);
    check("readyIdle", oPixelReady, 0);
    if (mode == 0)
      check("centre11", cap11, {8'd100, 8'd90, 8'd80, 8'd60, 8'd50, 8'd40, 8'd20, 8'd10, 8'd0});
  endtask

  initial begin
    #1 checkZero("reset");
    repeat (2) @(posedge iClk);
    #3 iRst = 1'b0;
    runFrame(0, 1'b0, -1);
    runFrame(1, 1'b0, -1);
    runFrame(0, 1'b0, 7);
    runFrame(0, 1'b0, -1);
    runFrame(0, 1'b1, -1);
    for (int f = 0; f < 4; f++) runFrame(2, 1'b0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dtbdm_window_sequencer.md
# dtbdm_window_sequencer

Raster-to-window scheduler that feeds the DTBDM fringe decision stage. It accepts one 8-bit pixel per cycle from the frame source and buffers two image rows. For every image position it emits the 3x3 neighbourhood (a b c / d fij e / f g h) with a data-valid strobe, plus the one-cycle-delayed enable the fringe stage needs. It handles frame borders, end-of-frame flush and frame sequencing, and sits between the pixel source (Nios II DMA path) and the fringe/decision datapath.

## Interface
- pWidth, 640, pixels per image row (≥ 3)
- pHeight, 480, rows per frame (≥ 2)
- pColBits, 10, column/row counter width (2^pColBits > max(pWidth, pHeight))
- iClk  in  1  clock
- iRst  in  1  asynchronous, active-high reset
- iStart  in  1  one-cycle pulse: begin a frame (ignored unless IDLE)
- iPixelValid  in  1  iv8PixelIn valid
- iv8PixelIn  in  8  raster-order pixel
- oPixelReady  out  1  sequencer accepts a pixel this cycle
- ov8Pixel_a..ov8Pixel_h, ov8Pixel_fij  out  8 each  window pixels
- oDataValid  out  1  window outputs valid this cycle
- oEn  out  1  oDataValid delayed one cycle (fringe-stage enable)
- oBorder  out  1  window centre lies on row 0/last or column 0/last
- ovCol, ovRow  out  pColBits each  coordinates of the emitted centre
- oBusy  out  1  state ≠ IDLE
- oFrameDone  out  1  one-cycle pulse after the last window

## Operation
- Decided: one clock; reset is asynchronous and active-high (iClk, iRst).
- States: IDLE → (iStart) RUN → (last pixel accepted) FLUSH → (last window emitted) DONE → IDLE.
- IDLE:
  - oPixelReady=0; column/row input counters and emit counter cleared.
- RUN:
  - oPixelReady=1. Pixel accepted when iPixelValid&oPixelReady.
  - Input linear index k advances per accept and is written into the two-row line buffer.
  - Emission lags input by L = pWidth+1 positions: accept of index k ≥ L emits the window for centre k−L.
  - No input gaps are assumed away: emission advances only on accepts in RUN.
- FLUSH:
  - oPixelReady=0. Emits one window per cycle for the remaining L centres, with no input.
- DONE:
  - oFrameDone=1 for one cycle, then IDLE.
- Border rule:
  - Any neighbour outside the image is replaced by the centre value fij; oBorder=1.
  - Interior windows use true neighbours; oBorder=0.
- Ignored events:
  - iStart outside IDLE is ignored.
  - iPixelValid outside RUN is ignored (no accept).
- Reset:
  - Reset mid-frame returns to IDLE and clears all counters; buffered line data is don't-care.
- Reset values:
  - All outputs are 0 on reset: window pixels, oDataValid, oEn, oBorder, coordinates, oBusy, oFrameDone, oPixelReady.

## Timing
- Window latency: window for centre k appears registered on the cycle after the accept of pixel k+L, or the corresponding FLUSH cycle.
- oEn = oDataValid delayed by exactly one cycle, so the fringe stage's registered input and output enables line up.
- Exactly pWidth·pHeight oDataValid pulses per frame.
- Windows are in raster order, with ovCol/ovRow matching the centre.
- oFrameDone is asserted the cycle after the final oDataValid.
- oBusy drops the same cycle oFrameDone is asserted, because DONE→IDLE registers next.
- Sustained throughput is one window per accepted pixel; a frame takes pWidth·pHeight + L + 2 cycles with no stalls.
- Counter wrap: column resets to 0 after pWidth−1 and increments the row; the row counter never wraps within a frame.

## Structure
- Shared package/include dtbdm_pkg:
  - state encoding (IDLE, RUN, FLUSH, DONE)
  - window position indices a..h/fij
  - default pWidth/pHeight
- One sub-module, mLineBuffer:
  - single-port-read/write circular row store, pWidth×8, one instance per buffered row
  - read-before-write in the same cycle
- Sequencer holds counters, the 3×3 shift registers, the border mux and the FSM.

## Test plan
- Frame 4×3 (pWidth=4, pHeight=3), pixel k = 10k:
  - centre (1,1) emitted the cycle after accept of k=10
  - a=0 b=10 c=20 d=40 fij=50 e=60 f=80 g=90 h=100, oBorder=0
- Same frame, centre (0,0):
  - all neighbours = fij = 0, oBorder=1, ovCol=0 ovRow=0, emitted after accept of k=5
- Same frame, end of frame:
  - 12 oDataValid pulses total, last with ovCol=3 ovRow=2
  - oFrameDone 1 cycle later; oEn trails every oDataValid by 1 cycle
- iPixelValid toggling 1/0 every cycle in RUN:
  - window values are identical to the gap-free run
  - oDataValid occurs only on cycles following accepts
- iRst asserted after 7 accepts:
  - all outputs 0 immediately (async)
  - a following iStart plus a full frame reproduces the first test exactly
- iStart pulsed during RUN and during FLUSH:
  - no effect: count still 12 windows, one oFrameDone
